bo_soma_n: RTL and testbench

// Parametrised accumulate-and-count operating block with built-in control FSM.

---
 rtl/bo_soma_n_if.sv | 37 +++
 rtl/bo_soma_n.sv | 101 ++++++++++
 tb/tb_bo_soma_n.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bo_soma_n_if.sv
// ============================================================================
// Module     : bo_soma_n_if
// Description: Control, word-stream and result bundle for the bo_soma_n
//              accumulate-and-count block.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bo_soma_n_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int ACC_W  = 12
);
    logic              start;
    logic [CNT_W-1:0]  n;
    logic              clr;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  soma;
    logic              zero;
    logic              ovf;

    modport master (
        output start, n, clr, in_valid, in_data,
        input  in_ready, busy, done, soma, zero, ovf
    );

    modport slave (
        input  start, n, clr, in_valid, in_data,
        output in_ready, busy, done, soma, zero, ovf
    );
endinterface

`default_nettype wire

// File: rtl/bo_soma_n.sv
// ============================================================================
// Module     : bo_soma_n
// Description: Sums exactly n words accepted over valid/ready, then pulses
//              done. Optional macro BO_SAT_EN selects saturating accumulation.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module bo_soma_n #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int ACC_W  = 12
) (
    input  wire logic     clk,
    input  wire logic     rst,
    bo_soma_n_if.slave    bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;

    // One extra bit captures the carry out of the accumulator
    logic [ACC_W:0]   w_sum;

    always_comb begin
        w_sum   = {1'b0, acc_q} + (ACC_W+1)'(bus.in_data);
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = bus.n;
                    state_d = (bus.n != '0) ? c_ACC : c_DONE;
                end
            end
            c_ACC: begin
                if (bus.in_valid && (cnt_q != '0)) begin
`ifdef BO_SAT_EN
                    acc_d = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
                    acc_d = w_sum[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | w_sum[ACC_W];
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = c_DONE;
                    end
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // Abort overrides any start or handshake in the same cycle
        if (bus.clr) begin
            state_d = c_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready = (state_q == c_ACC);
    assign bus.busy     = (state_q != c_IDLE);
    assign bus.done     = (state_q == c_DONE);
    assign bus.soma     = acc_q;
    assign bus.zero     = (cnt_q == '0);
    assign bus.ovf      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bo_soma_n.sv
// ============================================================================
// Module     : tb_bo_soma_n
// Description: Scoreboard bench for bo_soma_n with directed and random runs.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bo_soma_n;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int ACC_W  = 8;
    localparam int MAXV   = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bo_soma_n_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

    bo_soma_n #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned soma;
        bit          ovf;
    } exp_t;

    exp_t        sb[$];
    int unsigned words[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer sum with wrap or clamp at the accumulator limit
    function automatic exp_t model(input int unsigned ws[$]);
        exp_t e;
        int unsigned s;
        s     = 0;
        e.ovf = 1'b0;
        foreach (ws[i]) begin
            if (s + ws[i] > MAXV) begin
                e.ovf = 1'b1;
`ifdef BO_SAT_EN
                s = MAXV;
`else
                s = (s + ws[i]) % (MAXV + 1);
`endif
            end else begin
                s = s + ws[i];
            end
        end
        e.soma = s;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_soma", bus.soma, e.soma);
                check("sb_ovf", bus.ovf, e.ovf);
                check("sb_zero", bus.zero, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run with the words in the global queue; gap cycles before each word
    task automatic run(input int max_gap, input bit poke_start);
        int n;
        n = words.size();
        sb.push_back(model(words));
        bus.start = 1'b1;
        bus.n     = CNT_W'(n);
        tick();
        bus.start = 1'b0;
        foreach (words[i]) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                bus.start    = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.n        = CNT_W'($urandom_range(0, 15));
                check("gap_busy_notzero", {30'd0, bus.busy, !bus.zero}, 3);
                tick();
            end
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(words[i]);
            begin
                int wait_cnt;
                wait_cnt = 0;
                while (bus.in_ready !== 1'b1 && wait_cnt < 20) begin
                    tick();
                    wait_cnt++;
                end
                if (wait_cnt == 20) check("in_ready_timeout", 0, 1);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        check("done_latency", bus.done, 1);
        check("done_no_ready", bus.in_ready, 0);
        // A start during the DONE cycle must be ignored
        bus.start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        bus.start = 1'b0;
        check("idle_after_done", bus.busy, 0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.n        = '0;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_soma", bus.soma, 0);
        check("rst_zero", bus.zero, 1);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ovf", bus.ovf, 0);
        rst = 1'b0;
        tick();

        words = '{5, 7, 9};
        run(0, 1'b0);
        check("basic_soma_held", bus.soma, 21);

        words = {};
        run(0, 1'b0);

        words = '{10, 20};
        run(4, 1'b0);
        check("stall_soma_held", bus.soma, 30);

        words = '{200, 100};
        run(0, 1'b0);
`ifdef BO_SAT_EN
        check("ovf_soma_held", bus.soma, 255);
`else
        check("ovf_soma_held", bus.soma, 44);
`endif
        check("ovf_held", bus.ovf, 1);

        // Abort after one of three words; the word offered with clr is dropped
        bus.start = 1'b1;
        bus.n     = CNT_W'(3);
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd33;
        tick();
        bus.clr     = 1'b1;
        bus.in_data = 8'd44;
        tick();
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_soma", bus.soma, 0);
        check("abort_zero", bus.zero, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_ovf", bus.ovf, 0);
        repeat (2) tick();

        words = '{4};
        run(0, 1'b0);
        check("after_abort_soma", bus.soma, 4);

        // Asynchronous reset in the middle of a run
        bus.start = 1'b1;
        bus.n     = CNT_W'(5);
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd50;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_soma", bus.soma, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_zero", bus.zero, 1);
        check("async_rst_ready", bus.in_ready, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int r = 0; r < 25; r++) begin
            int nw;
            nw    = int'($urandom_range(0, 15));
            words = {};
            for (int k = 0; k < nw; k++) words.push_back($urandom_range(0, 255));
            run(2, 1'b1);
        end

        repeat (5) tick();
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
